// File: rtl/vdot_sequencer.sv
// ---------------------------------------------------------------------------
// vdot_sequencer
//
// Collects sixteen half-precision element pairs into the packed operand
// vectors vA/vB, fires a single-cycle start pulse at the dot-product unit,
// waits (with a bounded timer) for its completion flag, and presents the
// result on a valid/ready handshake. Only one operation is in flight; the
// next vector load starts only after the result has been consumed.
//
// Ports
//   Clk1       in   1    clock, rising edge active
//   Rst        in   1    asynchronous active-high reset
//   in_valid   in   1    element pair on in_a/in_b is valid
//   in_ready   out  1    element pair accepted this cycle (LOAD state)
//   in_a       in   16   element of vector A
//   in_b       in   16   element of vector B
//   vA         out  256  packed vector A, element i at [16i+15:16i]
//   vB         out  256  packed vector B, same packing
//   vStart     out  1    one-cycle start pulse to the dot-product unit
//   vDone      in   1    completion flag from the dot-product unit
//   vOut       in   16   dot-product result, valid with vDone
//   vV         in   1    dot-product overflow flag, valid with vDone
//   res_valid  out  1    result available
//   res_ready  in   1    consumer accepts the result
//   res        out  16   captured result
//   res_V      out  1    captured overflow flag
//   res_err    out  1    result was produced by a timeout abort
//   busy       out  1    an operation (or partial load) is in progress
// ---------------------------------------------------------------------------
module vdot_sequencer #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic         Clk1,
    input  logic         Rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_a,
    input  logic [15:0]  in_b,
    output logic [255:0] vA,
    output logic [255:0] vB,
    output logic         vStart,
    input  logic         vDone,
    input  logic [15:0]  vOut,
    input  logic         vV,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [15:0]  res,
    output logic         res_V,
    output logic         res_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // The timer counts completed WAIT cycles; the abort fires on the cycle in
    // which it would reach TIMEOUT, so exactly TIMEOUT WAIT cycles elapse.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  timer;

    logic        accept;
    logic        done_hit;
    logic        expire;
    logic        res_take;

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        vStart    = 1'b0;
        accept    = 1'b0;
        done_hit  = 1'b0;
        expire    = 1'b0;
        res_take  = 1'b0;

        case (state)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (idx == 4'd15)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                vStart    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion in the expiry cycle wins over the abort.
                if (vDone) begin
                    done_hit  = 1'b1;
                    state_nxt = HOLD;
                end else if (timer == TIMER_LAST) begin
                    expire    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    res_take  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    assign busy = (state != LOAD) || (idx != 4'd0);

    // State, element index and WAIT timer
    always_ff @(posedge Clk1 or posedge Rst) begin
        if (Rst) begin
            state <= LOAD;
            idx   <= 4'd0;
            timer <= 8'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // idx wraps from 15 to 0 naturally on the final element.
                idx <= idx + 4'd1;
            end
            if (vStart) begin
                timer <= 8'd0;
            end else if (state == WAIT) begin
                timer <= timer + 8'd1;
            end
        end
    end

    // Operand vectors and result capture
    always_ff @(posedge Clk1 or posedge Rst) begin
        if (Rst) begin
            vA        <= '0;
            vB        <= '0;
            res_valid <= 1'b0;
            res       <= 16'd0;
            res_V     <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            if (accept) begin
                vA[{idx, 4'b0000} +: 16] <= in_a;
                vB[{idx, 4'b0000} +: 16] <= in_b;
            end
            if (done_hit) begin
                res       <= vOut;
                res_V     <= vV;
                res_err   <= 1'b0;
                res_valid <= 1'b1;
            end else if (expire) begin
                res       <= 16'd0;
                res_V     <= 1'b0;
                res_err   <= 1'b1;
                res_valid <= 1'b1;
            end else if (res_take) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdot_sequencer.sv
module tb_vdot_sequencer;

    localparam int TIMEOUT = 8;

    logic         Clk1 = 1'b0;
    logic         Rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_a = 16'd0;
    logic [15:0]  in_b = 16'd0;
    logic [255:0] vA;
    logic [255:0] vB;
    logic         vStart;
    logic         vDone;
    logic [15:0]  vOut = 16'd0;
    logic         vV = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [15:0]  res;
    logic         res_V;
    logic         res_err;
    logic         busy;

    // Dot-product unit model: done is start delayed by one register.
    logic dp_en = 1'b0;
    logic dp_done = 1'b0;
    logic vdone_force = 1'b0;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int start_cnt = 0;

    logic [15:0]  elemA [16];
    logic [15:0]  elemB [16];
    logic [255:0] expA;
    logic [255:0] expB;

    always #5 Clk1 = ~Clk1;

    assign vDone = dp_done | vdone_force;

    always @(posedge Clk1 or posedge Rst) begin
        if (Rst) dp_done <= 1'b0;
        else     dp_done <= dp_en & vStart;
    end

    always @(negedge Clk1) begin
        if (in_valid && in_ready) acc_cnt++;
        if (vStart) start_cnt++;
    end

    vdot_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .Clk1      (Clk1),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .vA        (vA),
        .vB        (vB),
        .vStart    (vStart),
        .vDone     (vDone),
        .vOut      (vOut),
        .vV        (vV),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .res_V     (res_V),
        .res_err   (res_err),
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
        end
    endtask

    // kind 0: all 0x3C00, kind 1: element i = i, kind 2: random
    task automatic fill(input int kind);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0:       begin elemA[i] = 16'h3C00; elemB[i] = 16'h3C00; end
                1:       begin elemA[i] = 16'(i);   elemB[i] = 16'(i); end
                default: begin elemA[i] = 16'($urandom); elemB[i] = 16'($urandom); end
            endcase
        end
        expA = '0;
        expB = '0;
        for (int i = 0; i < 16; i++) begin
            expA[16*i +: 16] = elemA[i];
            expB[16*i +: 16] = elemB[i];
        end
    endtask

    // gap 0: back-to-back, 1: valid toggles 1,0,1,0, 2: random idle cycles
    task automatic load(input int gap, input int first, input int last);
        if (first == 0) acc_cnt = 0;
        for (int i = first; i < last; i++) begin
            if (gap == 1 && i > 0) begin
                in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
                step();
            end
            if (gap == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
                    step();
                end
            end
            in_valid = 1'b1;
            in_a = elemA[i];
            in_b = elemB[i];
            if (i == 15) chk("no_start_before_16th", 32'(vStart), 32'd0);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Called in the first HOLD cycle; checks stability, then hands off.
    task automatic finish_result(input int hold, input logic [15:0] eres,
                                 input logic ev, input logic eerr, input bit spurious);
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            if (spurious && h < 2) begin
                vdone_force = 1'b1;
                vOut = 16'($urandom);
                vV = ~vV;
            end
            step();
            vdone_force = 1'b0;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_res", 32'(res), 32'(eres));
            chk("hold_resV", 32'(res_V), 32'(ev));
            chk("hold_err", 32'(res_err), 32'(eerr));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("post_hs_valid", 32'(res_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input int kind, input int gap, input logic [15:0] ov,
                           input logic ovv, input int hold, input bit spurious,
                           input bit spur_load);
        int n;
        int s0;
        fill(kind);
        dp_en = 1'b1;
        vOut = ov;
        vV = ovv;
        s0 = start_cnt;
        if (spur_load) begin
            load(gap, 0, 8);
            vdone_force = 1'b1;
            step();
            step();
            vdone_force = 1'b0;
            chk("spur_load_in_ready", 32'(in_ready), 32'd1);
            chk("spur_load_busy", 32'(busy), 32'd1);
            chk("spur_load_valid", 32'(res_valid), 32'd0);
            load(gap, 8, 16);
        end else begin
            load(gap, 0, 16);
        end
        // Garbage offered while not ready must not be consumed.
        in_valid = 1'b1;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        chk("start_after_last", 32'(vStart), 32'd1);
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd2);
        chkv("vA", vA, expA);
        chkv("vB", vB, expB);
        chk("accepts", 32'(acc_cnt), 32'd16);
        chk("start_pulses", 32'(start_cnt - s0), 32'd1);
        chk("res", 32'(res), 32'(ov));
        chk("res_V", 32'(res_V), 32'(ovv));
        chk("res_err", 32'(res_err), 32'd0);
        // Model values are as-returned; later spurious vDone changes vOut.
        finish_result(hold, ov, ovv, 1'b0, spurious);
        dp_en = 1'b0;
    endtask

    task automatic run_timeout(input bit late_done);
        logic [15:0] lo;
        logic        lv;
        fill(2);
        dp_en = 1'b0;
        load(0, 0, 16);
        chk("tmo_start", 32'(vStart), 32'd1);
        for (int t = 0; t < TIMEOUT; t++) begin
            step();
            chk("tmo_wait_valid", 32'(res_valid), 32'd0);
        end
        lo = 16'($urandom);
        lv = 1'($urandom);
        if (late_done) begin
            vOut = lo;
            vV = lv;
            vdone_force = 1'b1;
        end
        step();
        vdone_force = 1'b0;
        chk("tmo_valid", 32'(res_valid), 32'd1);
        chk("tmo_err", 32'(res_err), late_done ? 32'd0 : 32'd1);
        chk("tmo_res", 32'(res), late_done ? 32'(lo) : 32'd0);
        chk("tmo_resV", 32'(res_V), late_done ? 32'(lv) : 32'd0);
        chkv("tmo_vA", vA, expA);
        finish_result(1, late_done ? lo : 16'd0, late_done ? lv : 1'b0,
                      late_done ? 1'b0 : 1'b1, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chkv("rst_vA", vA, '0);
        chkv("rst_vB", vB, '0);
        chk("rst_vStart", 32'(vStart), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_resV", 32'(res_V), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2 Rst = 1'b1;
        step();
        step();
        chk_reset_outputs();
        Rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        step();

        // All-ones vectors, back-to-back load, fixed result
        run_txn(0, 0, 16'h4C00, 1'b0, 0, 1'b0, 1'b0);
        // Element i = i with toggling valid
        run_txn(1, 1, 16'($urandom), 1'b0, 1, 1'b0, 1'b0);
        // Overflow result held for 5 cycles with spurious vDone in HOLD
        run_txn(2, 0, 16'h7C00, 1'b1, 5, 1'b1, 1'b0);
        // Timeout abort, then completion in the expiry cycle
        run_timeout(1'b0);
        run_timeout(1'b1);

        // Reset after 7 accepted pairs, then a fresh full load
        fill(2);
        load(0, 0, 7);
        chk("partial_elem6", 32'(vA[96 +: 16]), 32'(elemA[6]));
        chk("partial_busy", 32'(busy), 32'd1);
        Rst = 1'b1;
        #1;
        chk_reset_outputs();
        step();
        Rst = 1'b0;
        #1;
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_busy", 32'(busy), 32'd0);
        step();
        run_txn(2, 2, 16'($urandom), 1'($urandom), 2, 1'b0, 1'b0);

        // Reset in WAIT; a late vDone afterwards must be ignored
        fill(2);
        dp_en = 1'b0;
        load(0, 0, 16);
        step();
        step();
        step();
        Rst = 1'b1;
        #1;
        chk_reset_outputs();
        step();
        Rst = 1'b0;
        vOut = 16'hABCD;
        vdone_force = 1'b1;
        step();
        step();
        vdone_force = 1'b0;
        chk("late_done_valid", 32'(res_valid), 32'd0);
        chk("late_done_res", 32'(res), 32'd0);
        chk("late_done_in_ready", 32'(in_ready), 32'd1);
        chk("late_done_busy", 32'(busy), 32'd0);

        // Randomized transactions
        for (int r = 0; r < 6; r++) begin
            run_txn(2, 2, 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
